// File: rtl/bcd_seq_addsub_if.sv
// Operand/result bundle for the digit-serial BCD adder/subtractor.
// The acc signal exists only when BCD_ACCUM_EN is defined.
interface bcd_seq_addsub_if #(
  parameter int N_DIGITS = 4
) ();
  logic                  start;
  logic                  sub;
  logic [4*N_DIGITS-1:0] X;
  logic [4*N_DIGITS-1:0] Y;
`ifdef BCD_ACCUM_EN
  logic                  acc;
`endif
  logic [4*N_DIGITS-1:0] S;
  logic                  c_out;
  logic                  busy;
  logic                  done;
  logic                  invalid;

  modport master (
    output start,
    output sub,
    output X,
    output Y,
`ifdef BCD_ACCUM_EN
    output acc,
`endif
    input  S,
    input  c_out,
    input  busy,
    input  done,
    input  invalid
  );

  modport slave (
    input  start,
    input  sub,
    input  X,
    input  Y,
`ifdef BCD_ACCUM_EN
    input  acc,
`endif
    output S,
    output c_out,
    output busy,
    output done,
    output invalid
  );
endinterface

// File: rtl/bcd_seq_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock.
// Optional BCD_ACCUM_EN: acc=1 at accept takes X from the S register.
module bcd_seq_addsub #(
  parameter int N_DIGITS = 4
) (
  input logic            clk,
  input logic            reset_n,
  bcd_seq_addsub_if.slave bus
);
  localparam int W  = 4 * N_DIGITS;
  localparam int DW = $clog2(N_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  s_q, s_d;
  logic          sub_q, sub_d;
  logic          cy_q, cy_d;
  logic          cout_q, cout_d;
  logic          inv_q, inv_d;

  logic [W-1:0]  x_src;
  logic [3:0]    xd, yd, bd, sd;
  logic [4:0]    t;
  logic          cy;
  logic          bad;
  logic          last;

`ifdef BCD_ACCUM_EN
  assign x_src = bus.acc ? s_q : bus.X;
`else
  assign x_src = bus.X;
`endif

  always_comb begin
    xd = '0;
    yd = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (d_q == DW'(i)) begin
        xd = x_q[4*i +: 4];
        yd = y_q[4*i +: 4];
      end
    end
  end

  // Nine's complement plus initial carry=1 forms ten's complement.
  assign bd   = sub_q ? (4'd9 - yd) : yd;
  assign t    = {1'b0, xd} + {1'b0, bd} + {4'b0, cy_q};
  assign cy   = (t > 5'd9);
  assign sd   = cy ? (t[3:0] + 4'd6) : t[3:0];
  assign bad  = (xd > 4'd9) || (yd > 4'd9);
  assign last = (d_q == DW'(N_DIGITS - 1));

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    sub_d   = sub_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          x_d     = x_src;
          y_d     = bus.Y;
          sub_d   = bus.sub;
          d_d     = '0;
          cy_d    = bus.sub;
          cout_d  = 1'b0;
          inv_d   = 1'b0;
        end
      end
      RUN: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (d_q == DW'(i)) begin
            s_d[4*i +: 4] = sd;
          end
        end
        cy_d  = cy;
        inv_d = inv_q | bad;
        d_d   = d_q + DW'(1);
        if (last) begin
          state_d = DONE;
          cout_d  = sub_q ? ~cy : cy;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.c_out   = cout_q;
  assign bus.invalid = inv_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_bcd_seq_addsub.sv
// Bench for bcd_seq_addsub: decimal-arithmetic model plus directed vectors.
// Define BCD_ACCUM_EN for both RTL and bench to exercise accumulation.
module tb_bcd_seq_addsub;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] s;
    bit           c;
    bit           inv;
    bit           known;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bcd_seq_addsub_if #(.N_DIGITS(N)) bus ();

  bcd_seq_addsub #(.N_DIGITS(N)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit b = 0;
    for (int i = 0; i < N; i++) if (v[4*i +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit sb, input bit x_known);
    res_t   r;
    longint p = 1;
    longint xi, yi, v;
    for (int i = 0; i < N; i++) p = p * 10;
    xi = bcd2int(x);
    yi = bcd2int(y);
    if (sb) begin
      v   = xi - yi + p;
      r.c = (xi < yi);
    end else begin
      v   = xi + yi;
      r.c = (v >= p);
    end
    r.s     = int2bcd(v % p);
    r.inv   = has_bad(x) || has_bad(y);
    r.known = !r.inv && x_known;
    return r;
  endfunction

  // Model: cycles since accept, plus the decimal result of the operation.
  int           phase = 0;
  logic [W-1:0] m_s = '0;
  bit           m_c = 0;
  bit           m_inv = 0;
  bit           m_known = 1;
  bit           a_now;
  res_t         nxt;

`ifdef BCD_ACCUM_EN
  assign a_now = bus.acc;
`else
  assign a_now = 1'b0;
`endif

  always_comb begin
    nxt = model(a_now ? m_s : bus.X, bus.Y, bus.sub, a_now ? m_known : 1'b1);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= 0;
      m_s     <= '0;
      m_c     <= 1'b0;
      m_inv   <= 1'b0;
      m_known <= 1'b1;
    end else if (phase == 0) begin
      if (bus.start) begin
        phase   <= 1;
        m_s     <= nxt.s;
        m_c     <= nxt.c;
        m_inv   <= nxt.inv;
        m_known <= nxt.known;
      end
    end else if (phase == N + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", W'(bus.busy), W'(phase >= 1 && phase <= N));
    chk("done", W'(bus.done), W'(phase == N + 1));
    if (phase == 0 || phase == N + 1) begin
      chk("invalid", W'(bus.invalid), W'(m_inv));
      if (m_known) begin
        chk("S", bus.S, m_s);
        chk("c_out", W'(bus.c_out), W'(m_c));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit sb, input bit a, input bit poke,
                        input logic [W-1:0] es, input bit ec, input bit ei,
                        input string nm);
    int bz = 0;
    bit seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = x;
    bus.Y     = y;
    bus.sub   = sb;
`ifdef BCD_ACCUM_EN
    bus.acc   = a;
`else
    if (a) $display("note: acc ignored in %s", nm);
`endif
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) bz++;
      if (poke && k == 1) bus.start = 1'b1;
      if (poke && k == 2) bus.start = 1'b0;
      @(negedge clk);
    end
    chk({nm, " done seen"}, W'(seen), W'(1));
    chk({nm, " busy cycles"}, W'(bz), W'(N));
    chk({nm, " invalid"}, W'(bus.invalid), W'(ei));
    if (!ei) begin
      chk({nm, " S"}, bus.S, es);
      chk({nm, " c_out"}, W'(bus.c_out), W'(ec));
    end
    if (poke) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
`ifdef BCD_ACCUM_EN
    bus.acc   = 1'b0;
`endif
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset S", bus.S, '0);
    chk("reset busy", W'(bus.busy), '0);
    chk("reset done", W'(bus.done), '0);
    reset_n = 1'b1;

    run_op(16'h4355, 16'h2509, 0, 0, 0, 16'h6864, 0, 0, "add");
    run_op(16'h8573, 16'h6636, 0, 0, 0, 16'h5209, 1, 0, "carry");
    run_op(16'h0434, 16'h8885, 0, 0, 0, 16'h9319, 0, 0, "nocarry");
    run_op(16'h4355, 16'h2509, 1, 0, 0, 16'h1846, 0, 0, "sub");
    run_op(16'h2509, 16'h4355, 1, 0, 1, 16'h8154, 1, 0, "borrow");
    run_op(16'h9999, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, "wrap");
    run_op(16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, "zero sub");

    // Abort mid-RUN: outputs clear at once and no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 16'h1234;
    bus.Y     = 16'h1111;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort S", bus.S, '0);
    chk("abort busy", W'(bus.busy), '0);
    chk("abort done", W'(bus.done), '0);
    chk("abort c_out", W'(bus.c_out), '0);
    chk("abort invalid", W'(bus.invalid), '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (N + 3) @(negedge clk);

    run_op(16'h1A11, 16'h1111, 0, 0, 0, '0, 0, 1, "invalid");
    run_op(16'h2250, 16'h4067, 0, 0, 0, 16'h6317, 0, 0, "after invalid");

`ifdef BCD_ACCUM_EN
    run_op(16'h0001, 16'h0001, 0, 0, 0, 16'h0002, 0, 0, "acc seed");
    run_op(16'h5555, 16'h0999, 0, 1, 0, 16'h1001, 0, 0, "acc 1");
    run_op(16'h5555, 16'h8999, 0, 1, 0, 16'h0000, 1, 0, "acc 2");
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout");
    $fatal(1, "watchdog");
  end
endmodule
